// File: rtl/gb_host_arbiter.sv
// Round-robin arbiter sharing one ghostbus host port between two masters.
// One transaction in flight at a time; strobes, acks and read data are all registered.
module gb_host_arbiter #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata,
    output logic          busy,
    output logic [1:0]    o_dbg_state
);
    // Handshake: a master raises req with we/addr/wdata stable and holds it until
    // its one-cycle ack; req still high in the cycle after ack is a new transaction.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

    state_t        r_state, w_state_n;
    logic [3:0]    r_cnt, w_cnt_n;
    logic          r_gnt_b, w_gnt_b_n;
    logic          r_last_b, w_last_b_n;
    logic          r_we, w_we_n;
    logic [AW-1:0] r_addr, w_addr_n;
    logic [DW-1:0] r_wdata, w_wdata_n;
    logic          r_wen, w_wen_n;
    logic          r_rstb, w_rstb_n;
    logic          r_a_ack, w_a_ack_n;
    logic          r_b_ack, w_b_ack_n;
    logic [DW-1:0] r_a_rdata, w_a_rdata_n;
    logic [DW-1:0] r_b_rdata, w_b_rdata_n;
    logic          r_busy, w_busy_n;
    logic          w_pick_b;
    logic          w_sel_we;

    // B wins when it is alone, or when both request and A was served last.
    assign w_pick_b = b_req & (~a_req | ~r_last_b);
    assign w_sel_we = w_pick_b ? b_we : a_we;

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_gnt_b_n   = r_gnt_b;
        w_last_b_n  = r_last_b;
        w_we_n      = r_we;
        w_addr_n    = r_addr;
        w_wdata_n   = r_wdata;
        w_wen_n     = 1'b0;
        w_rstb_n    = 1'b0;
        w_a_ack_n   = 1'b0;
        w_b_ack_n   = 1'b0;
        w_a_rdata_n = r_a_rdata;
        w_b_rdata_n = r_b_rdata;
        w_busy_n    = r_busy;
        case (r_state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    w_gnt_b_n  = w_pick_b;
                    w_last_b_n = w_pick_b;
                    w_we_n     = w_sel_we;
                    w_addr_n   = w_pick_b ? b_addr : a_addr;
                    w_wdata_n  = w_pick_b ? b_wdata : a_wdata;
                    w_wen_n    = w_sel_we;
                    w_rstb_n   = ~w_sel_we;
                    w_busy_n   = 1'b1;
                    w_state_n  = S_STROBE;
                end
            end
            S_STROBE: begin
                if (r_we) begin
                    w_a_ack_n = ~r_gnt_b;
                    w_b_ack_n = r_gnt_b;
                    w_state_n = S_ACK;
                end else begin
                    w_cnt_n   = LAT_M1;
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    if (r_gnt_b) w_b_rdata_n = gb_rdata;
                    else         w_a_rdata_n = gb_rdata;
                    w_a_ack_n = ~r_gnt_b;
                    w_b_ack_n = r_gnt_b;
                    w_state_n = S_ACK;
                end else begin
                    w_cnt_n = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                w_busy_n  = 1'b0;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_gnt_b   <= 1'b0;
            r_last_b  <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wen     <= 1'b0;
            r_rstb    <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_gnt_b   <= w_gnt_b_n;
            r_last_b  <= w_last_b_n;
            r_we      <= w_we_n;
            r_addr    <= w_addr_n;
            r_wdata   <= w_wdata_n;
            r_wen     <= w_wen_n;
            r_rstb    <= w_rstb_n;
            r_a_ack   <= w_a_ack_n;
            r_b_ack   <= w_b_ack_n;
            r_a_rdata <= w_a_rdata_n;
            r_b_rdata <= w_b_rdata_n;
            r_busy    <= w_busy_n;
        end
    end

    assign gb_addr     = r_addr;
    assign gb_wdata    = r_wdata;
    assign gb_wen      = r_wen;
    assign gb_rstb     = r_rstb;
    assign a_ack       = r_a_ack;
    assign b_ack       = r_b_ack;
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gb_host_arbiter.sv
// Directed bench for gb_host_arbiter: main build with RD_LATENCY=2 plus
// RD_LATENCY=1 and RD_LATENCY=15 builds driven from the A side only.
module tb_gb_host_arbiter;
    logic        gb_clk = 1'b0;
    logic        gb_rst = 1'b1;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [23:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        l1_a_req = 0, l15_a_req = 0;

    logic        a_ack, b_ack, gb_wen, gb_rstb, busy;
    logic [31:0] a_rdata, b_rdata, gb_wdata, gb_rdata;
    logic [23:0] gb_addr;
    logic [1:0]  dbg_state;

    logic        l1_a_ack, l1_b_ack, l1_wen, l1_rstb, l1_busy;
    logic [31:0] l1_a_rdata, l1_b_rdata, l1_wdata, l1_rdata;
    logic [23:0] l1_addr;
    logic [1:0]  l1_state;
    logic        l15_a_ack, l15_b_ack, l15_wen, l15_rstb, l15_busy;
    logic [31:0] l15_a_rdata, l15_b_rdata, l15_wdata, l15_rdata;
    logic [23:0] l15_addr;
    logic [1:0]  l15_state;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 gb_clk = ~gb_clk;

    gb_host_arbiter #(.AW(24), .DW(32), .RD_LATENCY(2)) dut (
        .gb_clk(gb_clk), .gb_rst(gb_rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(gb_rdata),
        .busy(busy), .o_dbg_state(dbg_state)
    );

    gb_host_arbiter #(.AW(24), .DW(32), .RD_LATENCY(1)) dut_l1 (
        .gb_clk(gb_clk), .gb_rst(gb_rst),
        .a_req(l1_a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(l1_a_ack), .a_rdata(l1_a_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(24'h0), .b_wdata(32'h0), .b_ack(l1_b_ack), .b_rdata(l1_b_rdata),
        .gb_addr(l1_addr), .gb_wdata(l1_wdata), .gb_wen(l1_wen), .gb_rstb(l1_rstb), .gb_rdata(l1_rdata),
        .busy(l1_busy), .o_dbg_state(l1_state)
    );

    gb_host_arbiter #(.AW(24), .DW(32), .RD_LATENCY(15)) dut_l15 (
        .gb_clk(gb_clk), .gb_rst(gb_rst),
        .a_req(l15_a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(l15_a_ack), .a_rdata(l15_a_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(24'h0), .b_wdata(32'h0), .b_ack(l15_b_ack), .b_rdata(l15_b_rdata),
        .gb_addr(l15_addr), .gb_wdata(l15_wdata), .gb_wen(l15_wen), .gb_rstb(l15_rstb), .gb_rdata(l15_rdata),
        .busy(l15_busy), .o_dbg_state(l15_state)
    );

    // Bus model: read data is only valid in the single cycle RD_LATENCY cycles after the strobe.
    function automatic logic [31:0] rd_val(input logic [23:0] a);
        return {8'h00, a} + 32'h0000_00A0;
    endfunction

    logic [15:0] dly_m, dly_1, dly_15;
    always @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            dly_m  <= '0;
            dly_1  <= '0;
            dly_15 <= '0;
        end else begin
            dly_m  <= {dly_m[14:0], gb_rstb};
            dly_1  <= {dly_1[14:0], l1_rstb};
            dly_15 <= {dly_15[14:0], l15_rstb};
        end
    end
    assign gb_rdata = dly_m[1]   ? rd_val(gb_addr)  : 32'hBAD0_0000;
    assign l1_rdata = dly_1[0]   ? rd_val(l1_addr)  : 32'hBAD0_0001;
    assign l15_rdata = dly_15[14] ? rd_val(l15_addr) : 32'hBAD0_000F;

    task automatic step();
        @(posedge gb_clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (gb_addr !== 24'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", gb_addr); end
        n_cmp++; if (gb_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", gb_wdata); end
        n_cmp++; if ({gb_wen, gb_rstb, a_ack, b_ack, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 00000", {gb_wen, gb_rstb, a_ack, b_ack, busy}); end
        n_cmp++; if ({a_rdata, b_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {a_rdata, b_rdata}); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        gb_rst = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        a_req = 1; a_we = 1; a_addr = 24'h000010; a_wdata = 32'hDEADBEEF;
        step();
        n_cmp++; if ({gb_wen, gb_rstb, busy} !== 3'b101) begin n_fail++; $display("FAIL wr_strobe: got %b want 101", {gb_wen, gb_rstb, busy}); end
        n_cmp++; if (gb_addr !== 24'h000010) begin n_fail++; $display("FAIL wr_addr: got %h want 000010", gb_addr); end
        n_cmp++; if (gb_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeef", gb_wdata); end
        n_cmp++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack: got %b want 0", a_ack); end
        step();
        n_cmp++; if ({gb_wen, a_ack, b_ack} !== 3'b010) begin n_fail++; $display("FAIL wr_ack: got %b want 010", {gb_wen, a_ack, b_ack}); end
        a_req = 0;
        step();
        n_cmp++; if ({a_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_done: got %b want 00", {a_ack, busy}); end
    endtask

    task automatic test_single_read();
        b_req = 1; b_we = 0; b_addr = 24'h000021; b_wdata = 32'h0;
        step();
        n_cmp++; if ({gb_rstb, gb_wen} !== 2'b10) begin n_fail++; $display("FAIL rd_strobe: got %b want 10", {gb_rstb, gb_wen}); end
        n_cmp++; if (gb_addr !== 24'h000021) begin n_fail++; $display("FAIL rd_addr: got %h want 000021", gb_addr); end
        for (int k = 2; k <= 3; k++) begin
            step();
            n_cmp++; if ({gb_rstb, b_ack} !== 2'b00) begin n_fail++; $display("FAIL rd_wait_k%0d: got %b want 00", k, {gb_rstb, b_ack}); end
        end
        step();
        n_cmp++; if ({b_ack, a_ack} !== 2'b10) begin n_fail++; $display("FAIL rd_ack: got %b want 10", {b_ack, a_ack}); end
        n_cmp++; if (b_rdata !== 32'h000000C1) begin n_fail++; $display("FAIL rd_data: got %h want 000000c1", b_rdata); end
        n_cmp++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_other_rdata: got %h want 0", a_rdata); end
        b_req = 0;
        step();
        n_cmp++; if ({b_ack, b_rdata} !== {1'b0, 32'h000000C1}) begin n_fail++; $display("FAIL rd_hold: got %b/%h want 0/000000c1", b_ack, b_rdata); end
    endtask

    task automatic test_contention();
        a_req = 1; a_we = 1; a_addr = 24'h000100; a_wdata = 32'h11111111;
        b_req = 1; b_we = 0; b_addr = 24'h000200;
        // Expected grants A,B,A,B: A writes ack at +2 and +10, B reads ack at +7 and +15.
        for (int k = 1; k <= 16; k++) begin
            step();
            n_cmp++; if (a_ack !== (k == 2 || k == 10)) begin n_fail++; $display("FAIL cont_a_ack_k%0d: got %b", k, a_ack); end
            n_cmp++; if (b_ack !== (k == 7 || k == 15)) begin n_fail++; $display("FAIL cont_b_ack_k%0d: got %b", k, b_ack); end
            if (k == 2 || k == 10) begin
                n_cmp++; if (gb_addr !== 24'h000100) begin n_fail++; $display("FAIL cont_a_addr_k%0d: got %h want 000100", k, gb_addr); end
            end
            if (k == 7 || k == 15) begin
                n_cmp++; if ({gb_addr, b_rdata} !== {24'h000200, 32'h000002A0}) begin
                    n_fail++; $display("FAIL cont_b_k%0d: got %h/%h want 000200/000002a0", k, gb_addr, b_rdata); end
            end
            if (k == 15) begin a_req = 0; b_req = 0; end
        end
    endtask

    task automatic test_back_to_back();
        a_req = 1; a_we = 1; a_addr = 24'h000300; a_wdata = 32'h00000300;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k <= 15) begin
                n_cmp++; if (gb_wen !== (k % 3 == 1)) begin n_fail++; $display("FAIL hog_wen_k%0d: got %b", k, gb_wen); end
                n_cmp++; if ({a_ack, b_ack} !== {1'(k % 3 == 2), 1'b0}) begin n_fail++; $display("FAIL hog_ack_k%0d: got %b", k, {a_ack, b_ack}); end
                n_cmp++; if (busy !== (k % 3 != 0)) begin n_fail++; $display("FAIL hog_busy_k%0d: got %b", k, busy); end
                if (k % 3 == 1) begin
                    n_cmp++; if (gb_addr !== 24'(24'h300 + (k - 1) / 3)) begin
                        n_fail++; $display("FAIL hog_addr_k%0d: got %h want %h", k, gb_addr, 24'(24'h300 + (k - 1) / 3)); end
                end
                if (k % 3 == 2) begin
                    a_addr = 24'(24'h300 + (k - 2) / 3 + 1);
                    a_wdata = {8'h0, a_addr};
                end
                if (k == 14) begin b_req = 1; b_we = 1; b_addr = 24'h000400; b_wdata = 32'h00000044; end
            end
            if (k == 16) begin
                n_cmp++; if ({gb_wen, gb_addr, gb_wdata} !== {1'b1, 24'h000400, 32'h00000044}) begin
                    n_fail++; $display("FAIL hog_b_grant: got %b/%h/%h want 1/000400/00000044", gb_wen, gb_addr, gb_wdata); end
            end
            if (k == 17) begin
                n_cmp++; if ({b_ack, a_ack} !== 2'b10) begin n_fail++; $display("FAIL hog_b_ack: got %b want 10", {b_ack, a_ack}); end
                a_req = 0; b_req = 0;
            end
            if (k == 18) begin
                n_cmp++; if ({busy, a_ack, b_ack} !== 3'b000) begin n_fail++; $display("FAIL hog_idle: got %b want 000", {busy, a_ack, b_ack}); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        a_req = 1; a_we = 0; a_addr = 24'h000500; a_wdata = 32'h0;
        step();
        step();
        n_cmp++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rst_pre_state: got %0d want 2", dbg_state); end
        gb_rst = 1;
        #1;
        n_cmp++; if ({gb_addr, gb_wdata} !== 56'h0) begin n_fail++; $display("FAIL rst_bus: got %h/%h want 0", gb_addr, gb_wdata); end
        n_cmp++; if ({gb_wen, gb_rstb, a_ack, b_ack, busy, dbg_state} !== 7'b0) begin
            n_fail++; $display("FAIL rst_ctl: got %b want 0", {gb_wen, gb_rstb, a_ack, b_ack, busy, dbg_state}); end
        n_cmp++; if ({a_rdata, b_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {a_rdata, b_rdata}); end
        step();
        n_cmp++; if ({a_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_hold: got %b want 00", {a_ack, busy}); end
        gb_rst = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                n_cmp++; if ({gb_rstb, gb_addr} !== {1'b1, 24'h000500}) begin
                    n_fail++; $display("FAIL rst_restart: got %b/%h want 1/000500", gb_rstb, gb_addr); end
            end
            n_cmp++; if (a_ack !== (k == 4)) begin n_fail++; $display("FAIL rst_ack_k%0d: got %b", k, a_ack); end
            if (k == 4) begin
                n_cmp++; if (a_rdata !== 32'h000005A0) begin n_fail++; $display("FAIL rst_rdata_after: got %h want 000005a0", a_rdata); end
                a_req = 0;
            end
        end
    endtask

    task automatic test_latency();
        a_we = 0; a_addr = 24'h000600; a_wdata = 32'h0;
        l1_a_req = 1; l15_a_req = 1;
        for (int k = 1; k <= 18; k++) begin
            step();
            n_cmp++; if (l1_a_ack !== (k == 3)) begin n_fail++; $display("FAIL lat1_ack_k%0d: got %b", k, l1_a_ack); end
            n_cmp++; if (l15_a_ack !== (k == 17)) begin n_fail++; $display("FAIL lat15_ack_k%0d: got %b", k, l15_a_ack); end
            if (k == 3) begin
                n_cmp++; if (l1_a_rdata !== 32'h000006A0) begin n_fail++; $display("FAIL lat1_data: got %h want 000006a0", l1_a_rdata); end
                l1_a_req = 0;
            end
            if (k == 17) begin
                n_cmp++; if (l15_a_rdata !== 32'h000006A0) begin n_fail++; $display("FAIL lat15_data: got %h want 000006a0", l15_a_rdata); end
                l15_a_req = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
